dot_accumulator: RTL
====================

DOT_ACCUMULATOR -- requirements
Module: dot_accumulator

Interface
REQ-001 Parameter ACC_W, default 20: accumulator and result width in bits.
REQ-002 Parameter LEN_W, default 8: width of the job-length field.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  job-start pulse; sampled only in IDLE.
REQ-006 length  input  LEN_W  number of products in the job; sampled with start.
REQ-007 in_valid  input  1  in_product holds a valid value.
REQ-008 in_ready  output  1  block accepts a product this cycle.
REQ-009 in_product  input  16  unsigned 8x8 product from the lookup multiplier.
REQ-010 out_valid  output  1  out_sum and out_overflow hold a valid result.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_sum  output  ACC_W  accumulated sum, modulo 2^ACC_W.
REQ-013 out_overflow  output  1  sticky flag: a carry out of the accumulator occurred during the job.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM states SHALL be IDLE, ACCUM and DONE.
REQ-016 IDLE: start=1 with length!=0 SHALL load remaining<=length, acc<=0 and ovf<=0, then go to ACCUM.
REQ-017 IDLE: start=1 with length==0 SHALL load acc<=0 and ovf<=0, then go to DONE, giving a zero result one cycle after start.
REQ-018 in_ready SHALL be 1 exactly when the state is ACCUM; it is decoded from registered state only.
REQ-019 A handshake is in_valid&in_ready; on each handshake acc<=acc+zero-extend(in_product), computed ACC_W+1 bits wide.
REQ-020 The carry out of the accumulator add SHALL set ovf and keep it set until the next job start; acc keeps the low ACC_W bits.
REQ-021 Each handshake SHALL decrement remaining; a handshake with remaining==1 SHALL move the FSM to DONE.
REQ-022 in_valid=0 in ACCUM SHALL hold acc, ovf, remaining and state.
REQ-023 Throughput SHALL be one product per cycle; there is no bubble between consecutive handshakes.
REQ-024 DONE: out_valid=1, out_sum=acc, out_overflow=ovf; outputs are registered values.
REQ-025 out_valid SHALL assert in the cycle after the last product handshake.
REQ-026 DONE with out_ready=1 SHALL return to IDLE on that edge; with out_ready=0 all outputs SHALL hold stable.
REQ-027 start SHALL be ignored in ACCUM and DONE; a new job may start at the earliest in the cycle after return to IDLE.
REQ-028 out_valid SHALL be 0 and out_sum/out_overflow SHALL hold their last values in IDLE and ACCUM.

Reset
REQ-029 rst=1 SHALL immediately, without a clock, force state IDLE and acc=0, ovf=0, remaining=0.
REQ-030 Therefore in_ready=0, out_valid=0, out_sum=0, out_overflow=0 and busy=0 during reset.
REQ-031 Reset in ACCUM or DONE SHALL abandon the job; no partial result is presented afterwards.

Structure
REQ-032 The shared package SHALL hold the state enumeration (IDLE, ACCUM, DONE) and the default ACC_W, LEN_W and product width (16).
REQ-033 The accumulator add SHALL be a sub-module acc_adder: a parameterised ACC_W-bit adder with carry-out, consistent with the existing adder block.
REQ-034 All other logic SHALL live in dot_accumulator with no further hierarchy.

Verification
REQ-035 Stimulus: length=3; products 100, 200, 300 back-to-back. Response: out_valid one cycle after the 3rd handshake, out_sum=600, out_overflow=0.
REQ-036 Stimulus: length=17; every product 65535. Response: out_sum=65519 (0x0FFEF), out_overflow=1.
REQ-037 Stimulus: length=0 with start. Response: out_valid on the next cycle, out_sum=0, in_ready never asserted.
REQ-038 Stimulus: length=4 with in_valid gaps; out_ready held 0 for 5 cycles in DONE; start pulsed during DONE. Response: correct sum held stable, start ignored, IDLE after out_ready.
REQ-039 Stimulus: rst asynchronous pulse after 2 of 5 products. Response: all outputs 0 at once. Stimulus: next job length=2, products 7 and 9. Response: out_sum=16, out_overflow=0.

Source files
------------

// File: rtl/dot_accumulator_pkg.sv
// Shared definitions for the dot-product accumulator: FSM state encoding and
// default widths used by the accumulator and its adder.
package dot_accumulator_pkg;

    localparam int ACC_W_DEF = 20;
    localparam int LEN_W_DEF = 8;
    localparam int PROD_W    = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/dot_accumulator_acc_adder.sv
// Parameterised unsigned adder with carry-out; the carry feeds the sticky
// overflow flag of the accumulator.
module acc_adder #(
    parameter int WIDTH = 20
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    // One bit wider than the operands so the carry falls out of the add.
    assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/dot_accumulator.sv
// Accumulates a job of `length` unsigned products into an ACC_W-bit sum with a
// sticky overflow flag, then presents the result until the consumer takes it.
module dot_accumulator
    import dot_accumulator_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  length,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_overflow,
    output logic              busy
);

    state_t           state;
    state_t           state_next;
    logic [LEN_W-1:0] remaining;
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic [ACC_W-1:0] sum_q;
    logic             ovf_q;
    logic [ACC_W-1:0] add_sum;
    logic             add_carry;
    logic             handshake;
    logic             last_beat;
    logic             job_start;
    logic             zero_len;

    acc_adder #(
        .WIDTH (ACC_W)
    ) u_acc_adder (
        .a     (acc),
        .b     (ACC_W'(in_product)),
        .sum   (add_sum),
        .carry (add_carry)
    );

    assign job_start = (state == IDLE) && start;
    assign zero_len  = (length == '0);
    assign handshake = in_valid && in_ready;
    assign last_beat = handshake && (remaining == LEN_W'(1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = zero_len ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (last_beat) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Working accumulator; the result registers below are only written when
    // a job completes so the outputs hold their last value meanwhile.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining <= '0;
            acc       <= '0;
            ovf       <= 1'b0;
        end else if (job_start) begin
            remaining <= length;
            acc       <= '0;
            ovf       <= 1'b0;
        end else if (handshake) begin
            remaining <= remaining - LEN_W'(1);
            acc       <= add_sum;
            ovf       <= ovf | add_carry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
            ovf_q <= 1'b0;
        end else if (job_start && zero_len) begin
            sum_q <= '0;
            ovf_q <= 1'b0;
        end else if (last_beat) begin
            sum_q <= add_sum;
            ovf_q <= ovf | add_carry;
        end
    end

    assign out_sum      = sum_q;
    assign out_overflow = ovf_q;

endmodule
